usb_audio_playout_ctrl: RTL and testbench

//  Paces bursty host-to-device audio from the USB audio core (about 48 stereo samples per 1 ms frame) onto the DAC.

---
 rtl/usb_audio_playout_ctrl.sv | 82 ++++++++
 tb/tb_usb_audio_playout_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/usb_audio_playout_ctrl.sv
// usb_audio_playout_ctrl: paces bursty USB audio through a prefill FIFO onto a fixed-rate DAC sample stream
module usb_audio_playout_ctrl #(
    parameter int DIV       = 1250,
    parameter int AW        = 7,
    parameter int START_LVL = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid_i,
    input  logic [15:0]   in_lch_i,
    input  logic [15:0]   in_rch_i,
    input  logic          mute_i,
    output logic [15:0]   audio_lch_o,
    output logic [15:0]   audio_rch_o,
    output logic          smp_strobe_o,
    output logic          playing_o,
    output logic [AW:0]   level_o,
    output logic          underrun_o,
    output logic          overflow_o
);
    localparam int LW = AW + 1;
    localparam logic [AW:0] DEPTH_L = LW'(2 ** AW);
    localparam logic [AW:0] START_L = LW'(START_LVL);
    typedef enum logic {FILL, PLAY} state_t;
    state_t        state_q, state_d;
    logic [15:0]   tcnt_q, tcnt_d;
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   level_q, level_d;
    logic [31:0]   mem [2 ** AW];
    logic [15:0]   lch_q, rch_q;
    logic          str_q, ur_q, ov_q;
    logic          tick, empty, start, pop, wr;
    always_comb begin
        tick    = tcnt_q == 16'(DIV - 1);
        tcnt_d  = tick ? '0 : tcnt_q + 16'd1;
        empty   = level_q == '0;
        start   = level_q >= START_L;
        pop     = tick & (state_q == PLAY) & ~empty;
        wr      = in_valid_i & ((level_q != DEPTH_L) | pop);
        level_d = level_q + LW'(wr) - LW'(pop);
        state_d = state_q;
        if (tick)
            state_d = (state_q == PLAY) ? (empty ? FILL : PLAY) : (start ? PLAY : FILL);
    end
    always_ff @(posedge clk)
        if (wr) mem[wptr_q] <= {in_lch_i, in_rch_i};
    // The output register doubles as the RAM read register so the FIFO maps onto block RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            tcnt_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            lch_q   <= '0;
            rch_q   <= '0;
            str_q   <= 1'b0;
            ur_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            level_q <= level_d;
            if (wr) wptr_q <= wptr_q + AW'(1);
            if (pop) rptr_q <= rptr_q + AW'(1);
            str_q <= tick & ~((state_q == FILL) & start);
            ur_q  <= tick & (state_q == PLAY) & empty;
            ov_q  <= in_valid_i & ~wr;
            if (tick) begin
                lch_q <= (pop & ~mute_i) ? mem[rptr_q][31:16] : '0;
                rch_q <= (pop & ~mute_i) ? mem[rptr_q][15:0] : '0;
            end
        end
    end
    assign audio_lch_o  = lch_q;
    assign audio_rch_o  = rch_q;
    assign smp_strobe_o = str_q;
    assign playing_o    = state_q == PLAY;
    assign level_o      = level_q;
    assign underrun_o   = ur_q;
    assign overflow_o   = ov_q;
endmodule

// File: tb/tb_usb_audio_playout_ctrl.sv
// tb_usb_audio_playout_ctrl: queue-based reference model plus directed playback scenarios for two prefill thresholds
module tb_usb_audio_playout_ctrl;
    localparam int DIV = 4;
    localparam int AW = 3;
    localparam int DEPTH = 8;
    localparam int S0 = 4;
    localparam int S1 = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic mute = 1'b0;
    logic [15:0] lch = '0, rch = '0;
    logic [15:0] al [2], ar [2];
    logic st [2], pl [2], ur [2], ov [2];
    logic [AW:0] lv [2];
    int vecs = 0, miscmp = 0;
    bit en = 1'b0;
    always #5 clk = ~clk;
    usb_audio_playout_ctrl #(.DIV(DIV), .AW(AW), .START_LVL(S0)) u0 (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_lch_i(lch), .in_rch_i(rch), .mute_i(mute),
        .audio_lch_o(al[0]), .audio_rch_o(ar[0]), .smp_strobe_o(st[0]), .playing_o(pl[0]),
        .level_o(lv[0]), .underrun_o(ur[0]), .overflow_o(ov[0]));
    usb_audio_playout_ctrl #(.DIV(DIV), .AW(AW), .START_LVL(S1)) u1 (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_lch_i(lch), .in_rch_i(rch), .mute_i(mute),
        .audio_lch_o(al[1]), .audio_rch_o(ar[1]), .smp_strobe_o(st[1]), .playing_o(pl[1]),
        .level_o(lv[1]), .underrun_o(ur[1]), .overflow_o(ov[1]));
    // Reference model: a sample queue per instance, a phase counter, and a play flag.
    logic [31:0] mq [2][$];
    int ph = 0;
    bit play [2];
    logic [15:0] e_l [2], e_r [2];
    logic e_s [2], e_u [2], e_o [2];
    int lvl;
    bit tk;
    logic [31:0] x;
    always @(posedge clk) begin
        tk = ph == DIV - 1;
        ph <= rst ? 0 : (tk ? 0 : ph + 1);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                mq[k].delete();
                play[k] <= 1'b0;
                e_l[k] <= '0;
                e_r[k] <= '0;
                e_s[k] <= 1'b0;
                e_u[k] <= 1'b0;
                e_o[k] <= 1'b0;
            end else begin
                lvl = mq[k].size();
                e_s[k] <= tk && !(!play[k] && lvl >= (k == 0 ? S0 : S1));
                e_u[k] <= tk && play[k] && lvl == 0;
                if (tk) begin
                    if (play[k] && lvl != 0) begin
                        x = mq[k].pop_front();
                        e_l[k] <= mute ? 16'h0 : x[31:16];
                        e_r[k] <= mute ? 16'h0 : x[15:0];
                    end else begin
                        e_l[k] <= '0;
                        e_r[k] <= '0;
                    end
                    if (play[k] && lvl == 0) play[k] <= 1'b0;
                    else if (!play[k] && lvl >= (k == 0 ? S0 : S1)) play[k] <= 1'b1;
                end
                e_o[k] <= in_valid && mq[k].size() >= DEPTH;
                if (in_valid && mq[k].size() < DEPTH) mq[k].push_back({lch, rch});
            end
        end
    end
    task automatic chk(input string nm, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            miscmp++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    always @(negedge clk)
        if (en)
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("u%0d.audio_lch", k), int'(al[k]), int'(e_l[k]));
                chk($sformatf("u%0d.audio_rch", k), int'(ar[k]), int'(e_r[k]));
                chk($sformatf("u%0d.smp_strobe", k), int'(st[k]), int'(e_s[k]));
                chk($sformatf("u%0d.playing", k), int'(pl[k]), int'(play[k]));
                chk($sformatf("u%0d.level", k), int'(lv[k]), mq[k].size());
                chk($sformatf("u%0d.underrun", k), int'(ur[k]), int'(e_u[k]));
                chk($sformatf("u%0d.overflow", k), int'(ov[k]), int'(e_o[k]));
            end
    task automatic wait_str(input int k, input bit need_play);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (st[k] && (!need_play || pl[k])) return;
        end
        miscmp++;
        $display("FAIL u%0d.strobe_wait: no strobe within 20 cycles", k);
    endtask
    task automatic wait_play(input int k);
        for (int n = 0; n < 20; n++) begin
            if (pl[k]) return;
            @(negedge clk);
        end
        miscmp++;
        $display("FAIL u%0d.play_wait: playing never rose", k);
    endtask
    task automatic put(input logic [15:0] l, input logic [15:0] r);
        in_valid = 1'b1;
        lch = l;
        rch = r;
        @(negedge clk);
        in_valid = 1'b0;
    endtask
    initial begin
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) put(16'hAAAA, 16'h5555);
        rst = 1'b1;
        @(negedge clk);
        chk("rst.level", int'(lv[0]), 0);
        chk("rst.playing", int'(pl[0]), 0);
        chk("rst.audio", int'({al[0], ar[0]}), 0);
        chk("rst.flags", int'({st[0], ur[0], ov[0]}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) put(16'(i), 16'h8000 | 16'(i));
        wait_play(0);
        chk("start.playing", int'(pl[0]), 1);
        for (int i = 1; i <= 4; i++) begin
            wait_str(0, 1'b1);
            chk($sformatf("play.lch%0d", i), int'(al[0]), i);
            chk($sformatf("play.rch%0d", i), int'(ar[0]), 'h8000 + i);
        end
        wait_str(0, 1'b0);
        chk("ur.underrun", int'(ur[0]), 1);
        chk("ur.audio", int'({al[0], ar[0]}), 0);
        chk("ur.playing", int'(pl[0]), 0);
        chk("ur.level", int'(lv[0]), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 9; i++) put(16'h0010 + 16'(i), ~(16'h0010 + 16'(i)));
        chk("ovf.overflow", int'(ov[1]), 1);
        chk("ovf.level", int'(lv[1]), 8);
        wait_play(1);
        for (int n = 0; n < 8 && ph != DIV - 1; n++) @(negedge clk);
        put(16'h001A, ~16'h001A);
        chk("sim.overflow", int'(ov[1]), 0);
        chk("sim.level", int'(lv[1]), 8);
        chk("sim.strobe", int'(st[1]), 1);
        chk("sim.oldest", int'(al[1]), 'h11);
        mute = 1'b1;
        wait_str(1, 1'b1);
        chk("mute1.audio", int'({al[1], ar[1]}), 0);
        chk("mute1.level", int'(lv[1]), 7);
        wait_str(1, 1'b1);
        chk("mute2.audio", int'({al[1], ar[1]}), 0);
        chk("mute2.level", int'(lv[1]), 6);
        mute = 1'b0;
        wait_str(1, 1'b1);
        chk("unmute.lch", int'(al[1]), 'h14);
        chk("unmute.rch", int'(ar[1]), 'hFFEB);
        for (int i = 0; i < 5; i++) begin
            wait_str(1, 1'b1);
            chk($sformatf("drain.lch%0d", i), int'(al[1]), i == 4 ? 'h1A : 'h15 + i);
        end
        wait_str(1, 1'b0);
        chk("drain.underrun", int'(ur[1]), 1);
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
        $finish;
    end
endmodule
